// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback request, register-file write port and hazard signals
interface regfile_write_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   localparam int NREG = 2**ADDR_WIDTH;
   logic                  REQA_VALID;
   logic                  REQA_READY;
   logic [ADDR_WIDTH-1:0] REQA_ADDR;
   logic [DATA_WIDTH-1:0] REQA_DATA;
   logic                  REQB_VALID;
   logic                  REQB_READY;
   logic [ADDR_WIDTH-1:0] REQB_ADDR;
   logic [DATA_WIDTH-1:0] REQB_DATA;
   logic [ADDR_WIDTH-1:0] RD_ADDR1;
   logic [ADDR_WIDTH-1:0] RD_ADDR2;
   logic                  WRITE;
   logic [ADDR_WIDTH-1:0] INADDRESS;
   logic [DATA_WIDTH-1:0] IN;
   logic [NREG-1:0]       PENDING;
   logic                  HAZARD;
   logic                  STALL;
   modport master (
      output REQA_VALID, REQA_ADDR, REQA_DATA, REQB_VALID, REQB_ADDR, REQB_DATA, RD_ADDR1, RD_ADDR2,
      input  REQA_READY, REQB_READY, WRITE, INADDRESS, IN, PENDING, HAZARD, STALL
   );
   modport slave (
      input  REQA_VALID, REQA_ADDR, REQA_DATA, REQB_VALID, REQB_ADDR, REQB_DATA, RD_ADDR1, RD_ADDR2,
      output REQA_READY, REQB_READY, WRITE, INADDRESS, IN, PENDING, HAZARD, STALL
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port between ALU (A) and load (B) writeback
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter bit PROTECT_R0 = 1'b0
) (
   input logic                    CLK,
   input logic                    RESET,
   regfile_write_arbiter_if.slave bus
);
   localparam int NREG = 2**ADDR_WIDTH;
   typedef enum logic {PRIO_A, PRIO_B} prio_t;
   prio_t                 prio_q, prio_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_sel;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [NREG-1:0]       pending_q, pending_d;
   logic                  grant_a, grant_b, xfer;
   always_comb begin
      grant_a   = ~RESET & bus.REQA_VALID & (~bus.REQB_VALID | (prio_q == PRIO_A));
      grant_b   = ~RESET & bus.REQB_VALID & ~grant_a;
      xfer      = grant_a | grant_b;
      addr_sel  = grant_a ? bus.REQA_ADDR : bus.REQB_ADDR;
      prio_d    = grant_a ? PRIO_B : grant_b ? PRIO_A : prio_q;
      // protected r0 writes complete the handshake but never reach the register file
      write_d   = xfer & ~(PROTECT_R0 && (addr_sel == '0));
      addr_d    = xfer ? addr_sel : addr_q;
      data_d    = grant_a ? bus.REQA_DATA : grant_b ? bus.REQB_DATA : data_q;
      pending_d = (pending_q & ~(NREG'(write_q) << addr_q)) | (NREG'(write_d) << addr_d);
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         prio_q    <= PRIO_A;
         write_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         pending_q <= '0;
      end else begin
         prio_q    <= prio_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pending_q <= pending_d;
      end
   end
   assign bus.REQA_READY = grant_a;
   assign bus.REQB_READY = grant_b;
   assign bus.WRITE      = write_q;
   assign bus.INADDRESS  = addr_q;
   assign bus.IN         = data_q;
   assign bus.PENDING    = pending_q;
   assign bus.HAZARD     = pending_q[bus.RD_ADDR1] | pending_q[bus.RD_ADDR2];
   assign bus.STALL      = (bus.REQA_VALID & ~grant_a) | (bus.REQB_VALID & ~grant_b);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors for the write-port arbiter (instance built with r0 protection on)
module tb_regfile_write_arbiter;
   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] rf [8];
   int         n_vec = 0;
   int         n_err = 0;
   int         acc_a = 0;
   int         acc_b = 0;
   regfile_write_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();
   regfile_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .PROTECT_R0(1'b1)) dut (
      .CLK(CLK), .RESET(RESET), .bus(bus.slave)
   );
   always #5 CLK = ~CLK;
   // register-file model fed by the write port
   always @(posedge CLK) if (bus.WRITE === 1'b1) rf[bus.INADDRESS] <= bus.IN;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;
      RESET = 1'b1;
      bus.REQA_VALID = 1'b1; bus.REQA_ADDR = 3'd3; bus.REQA_DATA = 8'h2A;
      bus.REQB_VALID = 1'b0; bus.REQB_ADDR = 3'd0; bus.REQB_DATA = 8'h00;
      bus.RD_ADDR1 = 3'd3;   bus.RD_ADDR2 = 3'd0;
      for (int c = 0; c < 2; c++) begin
         tick(); #1;
         chk("rst_ready_a", bus.REQA_READY, 0);
         chk("rst_write", bus.WRITE, 0);
         chk("rst_pending", bus.PENDING, 8'h00);
         chk("rst_inaddr", bus.INADDRESS, 0);
      end
      RESET = 1'b0; #1;
      chk("rel_ready_a", bus.REQA_READY, 1);
      chk("rel_stall", bus.STALL, 0);
      tick(); bus.REQA_VALID = 1'b0; #1;
      chk("a_write", bus.WRITE, 1);
      chk("a_inaddr", bus.INADDRESS, 3);
      chk("a_in", bus.IN, 8'h2A);
      chk("a_pending", bus.PENDING, 8'h08);
      chk("a_hazard", bus.HAZARD, 1);
      chk("a_ready_drop", bus.REQA_READY, 0);
      tick(); #1;
      chk("a_commit_write", bus.WRITE, 0);
      chk("a_commit_pend", bus.PENDING, 8'h00);
      chk("a_commit_haz", bus.HAZARD, 0);
      chk("a_rf3", rf[3], 8'h2A);
      chk("a_hold_in", bus.IN, 8'h2A);
      // contention right after a reset, so PRIO favours A
      RESET = 1'b1; bus.RD_ADDR1 = 3'd0;
      tick(); RESET = 1'b0;
      bus.REQA_VALID = 1'b1; bus.REQA_ADDR = 3'd1; bus.REQA_DATA = 8'h11;
      bus.REQB_VALID = 1'b1; bus.REQB_ADDR = 3'd2; bus.REQB_DATA = 8'h22; #1;
      chk("con_ready_a", bus.REQA_READY, 1);
      chk("con_ready_b", bus.REQB_READY, 0);
      chk("con_stall1", bus.STALL, 1);
      tick(); bus.REQA_VALID = 1'b0; #1;
      chk("con_w1", bus.WRITE, 1);
      chk("con_addr1", bus.INADDRESS, 1);
      chk("con_in1", bus.IN, 8'h11);
      chk("con_ready_b2", bus.REQB_READY, 1);
      chk("con_stall2", bus.STALL, 0);
      tick(); bus.REQB_VALID = 1'b0; #1;
      chk("con_w2", bus.WRITE, 1);
      chk("con_addr2", bus.INADDRESS, 2);
      chk("con_in2", bus.IN, 8'h22);
      chk("con_pend2", bus.PENDING, 8'h04);
      tick(); #1;
      chk("con_rf1", rf[1], 8'h11);
      chk("con_rf2", rf[2], 8'h22);
      // fairness: last grant was B, so A is favoured first
      bus.REQA_VALID = 1'b1; bus.REQB_VALID = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("fair_a%0d", i), bus.REQA_READY, (i % 2) == 0);
         chk($sformatf("fair_b%0d", i), bus.REQB_READY, (i % 2) == 1);
         acc_a += int'(bus.REQA_READY);
         acc_b += int'(bus.REQB_READY);
         tick();
         bus.REQA_DATA = 8'h40 + 8'(i); bus.REQB_DATA = 8'h80 + 8'(i);
      end
      chk("fair_cnt_a", acc_a, 5);
      chk("fair_cnt_b", acc_b, 5);
      // a lone A grant leaves PRIO favouring B
      bus.REQB_VALID = 1'b0; bus.REQA_ADDR = 3'd4; bus.REQA_DATA = 8'h44;
      tick();
      bus.REQA_ADDR = 3'd5; bus.REQA_DATA = 8'hAA;
      bus.REQB_VALID = 1'b1; bus.REQB_ADDR = 3'd5; bus.REQB_DATA = 8'hBB; #1;
      chk("same_ready_b", bus.REQB_READY, 1);
      chk("same_ready_a", bus.REQA_READY, 0);
      tick(); bus.REQB_VALID = 1'b0; #1;
      chk("same_w1", bus.WRITE, 1);
      chk("same_in1", bus.IN, 8'hBB);
      chk("same_pend1", bus.PENDING, 8'h20);
      chk("same_ready_a2", bus.REQA_READY, 1);
      chk("rf4", rf[4], 8'h44);
      tick(); bus.REQA_VALID = 1'b0; #1;
      chk("same_w2", bus.WRITE, 1);
      chk("same_in2", bus.IN, 8'hAA);
      chk("same_pend2", bus.PENDING, 8'h20);
      tick(); #1;
      chk("same_w3", bus.WRITE, 0);
      chk("same_pend3", bus.PENDING, 8'h00);
      chk("same_rf5", rf[5], 8'hAA);
      // reset the cycle after an accept drops the staged write
      bus.REQA_VALID = 1'b1; bus.REQA_ADDR = 3'd6; bus.REQA_DATA = 8'h66;
      tick(); bus.REQA_VALID = 1'b0; RESET = 1'b1; #1;
      chk("mrst_staged", bus.WRITE, 1);
      chk("mrst_pend_set", bus.PENDING, 8'h40);
      tick(); RESET = 1'b0; #1;
      chk("mrst_write", bus.WRITE, 0);
      chk("mrst_pend", bus.PENDING, 8'h00);
      // protected r0: handshake completes, no write, no pending bit
      bus.REQB_VALID = 1'b1; bus.REQB_ADDR = 3'd0; bus.REQB_DATA = 8'h77; #1;
      chk("r0_ready_b", bus.REQB_READY, 1);
      tick(); bus.REQB_VALID = 1'b0; #1;
      chk("r0_write", bus.WRITE, 0);
      chk("r0_pend", bus.PENDING, 8'h00);
      tick(); #1;
      chk("r0_rf0", rf[0], 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
